// File: rtl/pulse_meter_pkg.sv
// Shared types and register-map constants for the pulse period meter.
package pulse_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } meter_state_t;

  localparam logic [1:0] REG_PERIOD  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CTRL    = 2'd2;
  localparam logic [1:0] REG_ELAPSED = 2'd3;

  localparam int STAT_VALID   = 0;
  localparam int STAT_TIMEOUT = 1;
  localparam int STAT_OVERRUN = 2;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_CLEAR  = 1;

endpackage

// File: rtl/sync_rise_detect.sv
// Two-flop synchronizer for an asynchronous input followed by a one-cycle rising-edge pulse.
module sync_rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d_async,
  output logic rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= d_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign rise = r_sync & ~r_prev;

endmodule

// File: rtl/pulse_period_meter.sv
// MMIO slot that measures the time between rising edges of pulse_in in whole milliseconds.
module pulse_period_meter
  import pulse_meter_pkg::*;
#(
  parameter int CNT_MAX    = 100_000,
  parameter int MIN_MS     = 200,
  parameter int TIMEOUT_MS = 3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [1:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  input  logic        pulse_in,
  output logic [1:0]  dbg_state
);

  localparam int PW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CNT_MAX - 1);

  meter_state_t  r_state;
  logic          r_enable;
  logic [PW-1:0] r_presc;
  logic [15:0]   r_elapsed;
  logic [15:0]   r_period;
  logic [15:0]   r_beat_cnt;
  logic          r_valid;
  logic          r_timeout;
  logic          r_overrun;

  logic          w_rise;
  logic          w_ctrl_wr;
  logic          w_clear;
  logic          w_enable_nxt;
  logic          w_rd_period;
  logic          w_tick;
  logic [PW-1:0] w_presc_nxt;
  logic [15:0]   w_elapsed_inc;
  logic          w_accept;
  logic          w_timeout_hit;
  logic          w_unused_wr;

  sync_rise_detect u_sync (
    .clk     (clk),
    .reset   (reset),
    .d_async (pulse_in),
    .rise    (w_rise)
  );

  // Bus strobes are single-cycle and qualified by cs; a read has no wait state.
  assign w_ctrl_wr    = cs & write & (addr == REG_CTRL);
  assign w_clear      = w_ctrl_wr & wr_data[CTRL_CLEAR];
  assign w_enable_nxt = w_ctrl_wr ? wr_data[CTRL_ENABLE] : r_enable;
  assign w_rd_period  = cs & read & (addr == REG_PERIOD);
  assign w_unused_wr  = &{1'b0, wr_data[31:2]};

  // Captured value includes this cycle's tick so period = floor(cycles / CNT_MAX).
  assign w_tick        = (r_state != ST_IDLE) && (r_presc == PRESC_LAST);
  assign w_presc_nxt   = w_tick ? '0 : r_presc + 1'b1;
  assign w_elapsed_inc = (w_tick && (r_elapsed != 16'hFFFF)) ? r_elapsed + 16'd1 : r_elapsed;
  assign w_accept      = (r_state == ST_MEASURE) && w_rise && (w_elapsed_inc >= 16'(MIN_MS));
  assign w_timeout_hit = (r_state == ST_MEASURE) && w_tick && (r_elapsed == 16'(TIMEOUT_MS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_enable   <= 1'b0;
      r_presc    <= '0;
      r_elapsed  <= '0;
      r_period   <= '0;
      r_beat_cnt <= '0;
      r_valid    <= 1'b0;
      r_timeout  <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_enable <= w_enable_nxt;
      if (w_clear) begin
        r_state    <= w_enable_nxt ? ST_ARM : ST_IDLE;
        r_presc    <= '0;
        r_elapsed  <= '0;
        r_period   <= '0;
        r_beat_cnt <= '0;
        r_valid    <= 1'b0;
        r_timeout  <= 1'b0;
        r_overrun  <= 1'b0;
      end else begin
        if (w_rd_period) begin
          r_valid   <= 1'b0;
          r_overrun <= 1'b0;
        end
        if (!w_enable_nxt) begin
          r_state   <= ST_IDLE;
          r_presc   <= '0;
          r_elapsed <= '0;
        end else begin
          case (r_state)
            ST_IDLE: begin
              r_state   <= ST_ARM;
              r_presc   <= '0;
              r_elapsed <= '0;
            end
            ST_ARM: begin
              if (w_rise) begin
                r_state   <= ST_MEASURE;
                r_presc   <= '0;
                r_elapsed <= '0;
              end else begin
                r_presc   <= w_presc_nxt;
                r_elapsed <= w_elapsed_inc;
              end
            end
            ST_MEASURE: begin
              if (w_accept) begin
                r_period   <= w_elapsed_inc;
                r_valid    <= 1'b1;
                r_overrun  <= w_rd_period ? 1'b0 : (r_overrun | r_valid);
                r_beat_cnt <= r_beat_cnt + 16'd1;
                r_presc    <= '0;
                r_elapsed  <= '0;
              end else begin
                r_presc   <= w_presc_nxt;
                r_elapsed <= w_elapsed_inc;
                if (w_timeout_hit) begin
                  r_timeout <= 1'b1;
                  r_state   <= ST_ARM;
                end
              end
            end
            default: r_state <= ST_IDLE;
          endcase
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      REG_PERIOD:  rd_data = {16'b0, r_period};
      REG_STATUS:  rd_data = {r_beat_cnt, 13'b0, r_overrun, r_timeout, r_valid};
      REG_ELAPSED: rd_data = {16'b0, r_elapsed};
      default:     rd_data = '0;
    endcase
  end

  assign dbg_state = r_state;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Scoreboard bench for pulse_period_meter with a cycle-arithmetic reference model.
module tb_pulse_period_meter;
  import pulse_meter_pkg::*;

  localparam int CNT  = 10;
  localparam int MINM = 3;
  localparam int TMO  = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cs = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic        pulse_in = 1'b0;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int p_cap = 0;
  logic st_req = 1'b0;
  logic done = 1'b0;

  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [1:0]  st_q[$];
  string       st_name_q[$];

  // Reference model: mode 0 idle, 1 armed, 2 measuring; m_last = cycle of reference edge
  int         m_mode = 0;
  bit         m_en = 0;
  int         m_last = 0;
  logic [15:0] m_period = '0;
  logic [15:0] m_beats = '0;
  bit         m_valid = 0;
  bit         m_overrun = 0;
  bit         m_timeout = 0;

  pulse_period_meter #(.CNT_MAX(CNT), .MIN_MS(MINM), .TIMEOUT_MS(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .cs        (cs),
    .read      (read),
    .write     (write),
    .addr      (addr),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .pulse_in  (pulse_in),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #(100000 * 10);
    $display("FAIL watchdog: time limit reached, got cyc=%0d required finish", cyc);
    $fatal(1, "watchdog");
  end

  // Monitor: pops an expectation whenever the DUT presents read data or a state probe
  always @(negedge clk) begin
    if (cs && read) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: got=%h required=no read", rd_data);
      end else begin
        automatic logic [31:0] e = exp_q.pop_front();
        automatic string n = name_q.pop_front();
        if (rd_data !== e) begin
          errors++;
          $display("FAIL %s: got=%h required=%h", n, rd_data, e);
        end
      end
    end
    if (st_req) begin
      automatic logic [1:0] es = st_q.pop_front();
      automatic string sn = st_name_q.pop_front();
      checks++;
      if (dbg_state !== es) begin
        errors++;
        $display("FAIL %s: state got=%0d required=%0d", sn, dbg_state, es);
      end
    end
    if (done) begin
      checks++;
      if (exp_q.size() != 0 || st_q.size() != 0) begin
        errors++;
        $display("FAIL queue_drain: got=%0d/%0d pending required=0/0", exp_q.size(), st_q.size());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_mode = 0; m_en = 0; m_last = 0; m_period = '0; m_beats = '0;
    m_valid = 0; m_overrun = 0; m_timeout = 0;
  endtask

  task automatic tmo_chk(input int c, input bit strict_gt);
    if (m_mode == 2) begin
      if ((strict_gt && (c - m_last > TMO * CNT)) || (!strict_gt && (c - m_last >= TMO * CNT))) begin
        m_mode = 1;
        m_timeout = 1;
      end
    end
  endtask

  function automatic logic [31:0] model_reg(input int a, input int c);
    logic [31:0] r;
    r = '0;
    case (a)
      0: r = {16'b0, m_period};
      1: r = {m_beats, 13'b0, m_overrun, m_timeout, m_valid};
      3: r = (m_mode == 2) ? 32'((c - m_last) / CNT) : 32'd0;
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic model_edge(input int c, input bit rd0);
    bit acc;
    acc = 0;
    tmo_chk(c, 1);
    if (m_mode == 1) begin
      m_mode = 2;
      m_last = c;
    end else if (m_mode == 2 && ((c - m_last) / CNT) >= MINM) begin
      acc = 1;
      m_overrun = rd0 ? 1'b0 : (m_overrun | m_valid);
      m_valid = 1;
      m_period = 16'((c - m_last) / CNT);
      m_beats = m_beats + 16'd1;
      m_last = c;
    end
    if (rd0 && !acc) begin
      m_valid = 0;
      m_overrun = 0;
    end
  endtask

  task automatic do_read(input int a, input string nm);
    tmo_chk(cyc, 0);
    exp_q.push_back(model_reg(a, cyc));
    name_q.push_back(nm);
    cs = 1; read = 1; addr = 2'(a);
    step();
    cs = 0; read = 0;
    if (a == 0) begin
      m_valid = 0;
      m_overrun = 0;
    end
  endtask

  task automatic do_write(input logic [31:0] d);
    tmo_chk(cyc, 0);
    cs = 1; write = 1; addr = REG_CTRL; wr_data = d;
    step();
    cs = 0; write = 0; wr_data = '0;
    m_en = d[0];
    if (d[1]) begin
      m_period = '0; m_beats = '0; m_valid = 0; m_overrun = 0; m_timeout = 0;
      m_mode = d[0] ? 1 : 0;
    end else if (!m_en) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end
  endtask

  task automatic check_state(input string nm);
    logic [1:0] es;
    tmo_chk(cyc, 0);
    es = (m_mode == 0) ? ST_IDLE : (m_mode == 1) ? ST_ARM : ST_MEASURE;
    st_q.push_back(es);
    st_name_q.push_back(nm);
    st_req = 1;
    step();
    st_req = 0;
  endtask

  // Pulse whose edge is captured at posedge tc; optional addr-0 read in the capture cycle
  task automatic pulse_at(input int tc, input bit rd0);
    while (cyc < tc - 3) step();
    pulse_in = 1;
    step();
    step();
    if (rd0) begin
      tmo_chk(cyc, 0);
      exp_q.push_back(model_reg(0, cyc));
      name_q.push_back("simul_read_data");
      cs = 1; read = 1; addr = REG_PERIOD;
    end
    step();
    cs = 0; read = 0;
    p_cap = cyc;
    model_edge(cyc, rd0);
    pulse_in = 0;
    step();
  endtask

  initial begin
    int base;
    int g;
    int tc;
    int a;

    model_reset();
    step(); step(); step();
    reset = 1;
    step();

    do_read(0, "reset_period");
    do_read(1, "reset_status");
    do_read(2, "reset_ctrl");
    do_read(3, "reset_elapsed");
    check_state("reset_state");

    pulse_at(cyc + 6, 0);
    do_read(1, "idle_edge_ignored");

    // Basic measurement
    do_write(32'h1);
    check_state("arm_after_enable");
    pulse_at(cyc + 6, 0);
    base = p_cap;
    pulse_at(base + 50, 0);
    do_read(0, "basic_period");
    do_read(1, "basic_status");
    do_read(1, "basic_after_read0");
    while (cyc < p_cap + 27) step();
    do_read(3, "elapsed_live");

    // Glitch rejection
    base = p_cap;
    pulse_at(base + 15, 0);
    do_read(1, "glitch_status");
    pulse_at(base + 60, 0);
    do_read(0, "glitch_period");

    // Overrun
    pulse_at(p_cap + 40, 0);
    pulse_at(p_cap + 70, 0);
    do_read(1, "overrun_status");
    do_read(0, "overrun_period");
    do_read(1, "overrun_cleared");

    // Read of addr 0 in the capture cycle
    pulse_at(p_cap + 45, 0);
    pulse_at(p_cap + 38, 1);
    do_read(1, "simul_status");
    do_read(0, "simul_period");

    // Randomized gaps and reads
    for (int i = 0; i < 14; i++) begin
      g = $urandom_range(12, 120);
      tc = p_cap + g;
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(0, 1) == 1 && cyc + 2 < tc - 3) begin
          a = $urandom_range(0, 3);
          if (a == 3 && m_mode != 2) a = 1;
          do_read(a, "rand_read");
        end
      end
      pulse_at(tc, $urandom_range(0, 3) == 0);
    end
    do_read(1, "rand_final_status");

    // Timeout
    pulse_at(p_cap + 50, 0);
    base = p_cap;
    while (cyc < base + 215) step();
    check_state("timeout_state_arm");
    do_read(1, "timeout_status");
    do_read(0, "timeout_period_kept");
    pulse_at(cyc + 10, 0);
    do_read(1, "timeout_next_edge_not_captured");
    check_state("measure_after_rearm");
    pulse_at(p_cap + 50, 0);
    do_read(0, "post_timeout_period");

    // Control: clear+enable, disable, reset mid-measure
    do_write(32'h3);
    do_read(0, "clear_period");
    do_read(1, "clear_status");
    check_state("clear_arm");
    do_write(32'h0);
    check_state("disable_idle");
    do_read(3, "disable_elapsed");
    pulse_at(cyc + 6, 0);
    do_read(1, "disable_edge_ignored");
    do_write(32'h1);
    pulse_at(cyc + 6, 0);
    pulse_at(p_cap + 50, 0);
    pulse_at(p_cap + 30, 0);
    step(); step(); step();
    reset = 0;
    model_reset();
    step();
    do_read(0, "midreset_period");
    do_read(1, "midreset_status");
    do_read(3, "midreset_elapsed");
    check_state("midreset_state");
    reset = 1;
    step();
    do_read(1, "after_reset_status");
    check_state("after_reset_state");

    done = 1;
    step();
    done = 0;
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pulse_period_meter.md
# pulse_period_meter

Measures the interval between rising edges of an external pulse input, such as a heart-pulse sensor comparator output, in whole milliseconds. Software reads the result over the MMIO slot bus. It is the read-side counterpart of the LED pulse generator core: that core turns a software-written period into a pulse, and this core turns a pulse into a software-readable period. It sits in an FPro-style MMIO slot, with `pulse_in` taken from a board pin.

## Interface
- `CNT_MAX`, default 100_000: clock cycles per millisecond tick (100 MHz clock).
- `MIN_MS`, default 200: edges arriving less than this many ms after the previous accepted edge are rejected as glitches.
- `TIMEOUT_MS`, default 3000: with no accepted edge for this many ms, the block flags a timeout and re-arms.
- `clk` input, 1 bit: single system clock.
- `reset` input, 1 bit: asynchronous, active-low reset (asserted at 0).
- `cs` input, 1 bit: slot select.
- `read` input, 1 bit: read strobe, one cycle.
- `write` input, 1 bit: write strobe, one cycle.
- `addr` input, 2 bits: register address.
- `wr_data` input, 32 bits: write data.
- `rd_data` output, 32 bits: combinational read mux.
- `pulse_in` input, 1 bit: asynchronous external pulse.

## Operation
- Register map:
  - addr 0 (R): `{16'b0, period_ms}`. A read clears `valid` and `overrun`.
  - addr 1 (R): `{beat_cnt[15:0], 13'b0, overrun, timeout, valid}`.
  - addr 2 (W): bit0 `enable`, bit1 `clear` (self-clearing strobe). Reads return 0.
  - addr 3 (R): `{16'b0, elapsed_ms}`, the live counter.
- Input path:
  - `pulse_in` passes through a 2-flop synchronizer, then a rising-edge detector.
  - The detector produces a 1-cycle `edge`.
- Timebase:
  - The prescaler counts 0 to `CNT_MAX`-1.
  - `tick` asserts when the prescaler equals `CNT_MAX`-1.
  - `elapsed_ms` is 16 bits, increments on `tick` and saturates at 0xFFFF.
- FSM states are IDLE, ARM and MEASURE.
  - **IDLE:** prescaler and `elapsed_ms` are held at 0; edges are ignored. Setting `enable`=1 moves to ARM.
  - **ARM:** on `edge`, zero the prescaler and `elapsed_ms`, then go to MEASURE. No capture is made.
  - **MEASURE, accepted edge** (`edge` with `elapsed_ms` ≥ `MIN_MS`):
    - `period_ms` ← `elapsed_ms`.
    - `overrun` ← `overrun | valid`; `valid` ← 1.
    - `beat_cnt` increments, wrapping at 0xFFFF to 0.
    - Prescaler and `elapsed_ms` restart at 0; stay in MEASURE.
  - **MEASURE, rejected edge** (`elapsed_ms` < `MIN_MS`): no state change.
  - **MEASURE, timeout** (`tick` when `elapsed_ms` = `TIMEOUT_MS`-1): `timeout` ← 1, go to ARM. `period_ms` is unchanged.
  - **Any state, `enable`=0:** go to IDLE. `period_ms`, flags and count are retained.
- Clear (`clear`=1):
  - Zeroes `period_ms`, `beat_cnt`, `valid`, `timeout`, `overrun`, the prescaler and `elapsed_ms`.
  - Goes to ARM if `enable`=1, otherwise IDLE.
- Simultaneous events:
  - Read of addr 0 in the same cycle as an accepted edge: the capture wins. `valid`=1, `overrun` is cleared, and `period_ms` takes the new value.
  - Clear in the same cycle as an edge: the clear wins and the edge is dropped.
  - A write that sets both `enable` and `clear`: clear is applied, then the block enters ARM.
- `timeout` is sticky and is cleared only by `clear`.

## Timing
- All outputs and registers reset to 0; the FSM resets to IDLE and `enable` resets to 0.
- `rd_data` is combinational from `addr` and registers. It is valid in the same cycle as `read`.
- The read side effect on addr 0 takes effect at the clock edge ending the read cycle.
- Latency from a `pulse_in` rising transition (meeting setup) to the `period_ms` update is 3 clock edges: 2 synchronizer edges plus 1 capture edge.
- Writes take effect on the clock edge of the `write` cycle.
- Quantization: `period_ms` = floor(cycles between accepted edges / `CNT_MAX`).
- Reset is asynchronous on assertion. Reset deassertion is synchronized externally.
- Reset mid-measurement discards all state.

## Structure
- Package `pulse_meter_pkg` holds:
  - the state enum `meter_state_t` (IDLE, ARM, MEASURE);
  - address constants `REG_PERIOD`, `REG_STATUS`, `REG_CTRL` and `REG_ELAPSED`;
  - status bit index constants.
- Sub-module `sync_rise_detect` contains the 2-flop synchronizer and the edge pulse. It takes parameters none, and has ports `clk`, `reset`, `d_async` and `rise`.

## Test plan
All scenarios use `CNT_MAX`=10, `MIN_MS`=3 and `TIMEOUT_MS`=20.
- **Basic measurement:** enable, then send rising edges 50 cycles apart. Reads return `period_ms`=5, `valid`=1 and `beat_cnt`=1 after the second edge; `valid`=0 after reading addr 0.
- **Glitch rejection:** an edge 15 cycles after an accepted edge is ignored and `beat_cnt` is unchanged. The next edge at 60 cycles yields `period_ms`=6.
- **Overrun:** two accepted periods with no read in between give `overrun`=1 and `period_ms` equal to the latest value. Reading addr 0 clears `valid` and `overrun`.
- **Timeout:** no edges for 200 cycles after arming in MEASURE give `timeout`=1, FSM in ARM and `period_ms` retained. The next edge is not captured.
- **Simultaneous read and capture:** a read of addr 0 on the capture cycle leaves `valid`=1, `overrun`=0 and the new `period_ms`.
- **Control:** writing 0x3 zeroes all registers and arms the block. Writing 0x0 goes to IDLE, with `elapsed_ms`=0 and edges ignored. Asserting `reset`=0 mid-MEASURE returns every register to 0.
